issue_scoreboard: RTL and testbench
===================================

// Module: issue_scoreboard
// PURPOSE
//  Issue-stage controller between the instruction decoder and the execute stage.
//  Tracks destination registers of long-latency ops (loads) still in flight.
//  Stalls any decoded instruction whose rs1/rs2/rd collide with a pending write.
//  Sequences flush/drain on redirect; counts stall cycles for performance monitoring.
// PARAMETERS
//  REG_WIDTH   5   register index width (2**REG_WIDTH architectural registers)
//  MAX_OUTST   4   max long-latency ops in flight (1..2**REG_WIDTH-1)
//  CNT_WIDTH   16  width of stall_cnt
// PORTS
//  clk          in   1          single clock; all state updates on rising edge
//  reset        in   1          synchronous, active-low; sampled on rising clk
//  dec_valid    in   1          decoded instruction present
//  dec_ready    out  1          scoreboard accepts the instruction this cycle
//  rs1, rs2     in   REG_WIDTH  source register indices from decoder
//  rs1e, rs2e   in   1          source index is valid
//  rd           in   REG_WIDTH  destination index from decoder
//  rde          in   1          destination write is valid
//  is_long      in   1          instruction is long-latency (load)
//  issue_valid  out  1          instruction forwarded to execute
//  issue_ready  in   1          execute accepts
//  wb_valid     in   1          long-latency writeback completes
//  wb_rd        in   REG_WIDTH  register written by that writeback
//  flush        in   1          pipeline redirect
//  pending      out  2**REG_WIDTH  pending-write mask, bit 0 always 0
//  outst        out  clog2(MAX_OUTST+1)  long ops in flight
//  stall_cnt    out  CNT_WIDTH  saturating stall-cycle counter
//  wb_err       out  1          sticky: writeback to non-pending register
// BEHAVIOUR
//  Reset (reset==0 at edge): pending=0, outst=0, stall_cnt=0, wb_err=0, state=RUN.
//  eff_pend = pending & ~(wb_valid ? onehot(wb_rd) : 0)  (same-cycle WB bypass).
//  hazard = (rs1e & eff_pend[rs1]) | (rs2e & eff_pend[rs2]) | (rde & eff_pend[rd])
//         | (is_long & rde & rd!=0 & outst==MAX_OUTST).
//  Register 0 never compared: index 0 reads as not pending, never set.
//  RUN: issue_valid = dec_valid & ~hazard; dec_ready = issue_ready & ~hazard.
//    fire = dec_valid & dec_ready; zero-latency combinational pass-through.
//  fire & is_long & rde & rd!=0: set pending[rd], outst+1.
//  wb_valid & pending[wb_rd]: clear bit, outst-1; if bit not set: no change, wb_err=1.
//  Same-cycle fire(set rd) and wb(clear rd): set wins, outst unchanged (+1 -1).
//  stall_cnt +1 each RUN cycle with dec_valid & ~dec_ready; holds at all-ones.
//  flush (any state, highest priority after reset): state->DRAIN; no fire that cycle.
//  DRAIN: issue_valid=0, dec_ready=0; writebacks still retire normally.
//    DRAIN->RUN on the cycle after outst==0 (pending then 0); stall_cnt frozen.
//  flush during DRAIN: stays DRAIN. Reset mid-DRAIN: immediate return to reset values.
//  issue_valid must not depend on issue_ready (no combinational loop on the handshake).
// TESTING
//  Load x5 issued (is_long, rd=5), next add rs1=5 -> issue_valid=0 until wb_valid,wb_rd=5; issues same cycle as WB.
//  4 loads to x1..x4, 5th load x6 -> stalled, outst=4; wb x2 -> 5th load fires, outst stays 4.
//  Load rd=0 -> pending stays 0, outst stays 0; later rs1=0 never stalls.
//  Fire load rd=7 while wb_rd=7 same cycle -> pending[7]=1, outst unchanged.
//  flush with outst=2 -> dec_ready=0; after 2 WBs, RUN resumes one cycle after outst==0.
//  wb_valid to non-pending x9 -> wb_err=1 sticky, outst unchanged; 70000 stall cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/issue_scoreboard_if.sv
// Decoder / execute / writeback handshake bundle for issue_scoreboard.
//   master : driven by the pipeline around the scoreboard (decoder, execute
//            handshake, writeback, redirect)
//   slave  : the scoreboard itself
// Signals:
//   dec_valid/dec_ready   decoder handshake
//   rs1/rs2/rd + enables  decoded register indices
//   is_long               instruction is a long-latency op (load)
//   issue_valid/ready     execute handshake
//   wb_valid/wb_rd        long-latency writeback completion
//   flush                 pipeline redirect
interface issue_scoreboard_if #(
  parameter int REG_WIDTH = 5
);
  logic                 dec_valid;
  logic                 dec_ready;
  logic [REG_WIDTH-1:0] rs1;
  logic [REG_WIDTH-1:0] rs2;
  logic                 rs1e;
  logic                 rs2e;
  logic [REG_WIDTH-1:0] rd;
  logic                 rde;
  logic                 is_long;
  logic                 issue_valid;
  logic                 issue_ready;
  logic                 wb_valid;
  logic [REG_WIDTH-1:0] wb_rd;
  logic                 flush;

  modport master (
    output dec_valid, rs1, rs2, rs1e, rs2e, rd, rde, is_long,
    output issue_ready, wb_valid, wb_rd, flush,
    input  dec_ready, issue_valid
  );

  modport slave (
    input  dec_valid, rs1, rs2, rs1e, rs2e, rd, rde, is_long,
    input  issue_ready, wb_valid, wb_rd, flush,
    output dec_ready, issue_valid
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue-stage scoreboard between decoder and execute.
// Tracks destination registers of in-flight long-latency ops, stalls any
// decoded instruction that touches a pending register, sequences a drain
// after a redirect and counts stall cycles.
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous, active-low
//   sb         handshake bundle (slave side)
//   pending    pending-write mask, bit 0 always 0
//   outst      number of long ops in flight
//   stall_cnt  saturating stall-cycle counter
//   wb_err     sticky: writeback hit a register that was not pending
module issue_scoreboard #(
  parameter  int REG_WIDTH = 5,
  parameter  int MAX_OUTST = 4,
  parameter  int CNT_WIDTH = 16,
  localparam int NREG      = 2**REG_WIDTH,
  localparam int OW        = $clog2(MAX_OUTST+1)
) (
  input  logic                 clk,
  input  logic                 reset,
  issue_scoreboard_if.slave    sb,
  output logic [NREG-1:0]      pending,
  output logic [OW-1:0]        outst,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic                 wb_err
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]      state;
  logic [0:0]      state_d;
  logic [NREG-1:0] wb_mask;
  logic [NREG-1:0] eff_pend;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] pending_d;
  logic [OW-1:0]   outst_d;
  logic            full;
  logic            hazard;
  logic            run;
  logic            fire;
  logic            set_en;
  logic            clr_en;
  logic            stall_inc;

  // A writeback landing this cycle already frees its register for the
  // instruction being decoded (same-cycle bypass).
  always_comb begin
    wb_mask  = sb.wb_valid ? (NREG'(1) << sb.wb_rd) : '0;
    eff_pend = pending & ~wb_mask;
    full     = (outst == OW'(MAX_OUTST));
    hazard   = (sb.rs1e & eff_pend[sb.rs1])
             | (sb.rs2e & eff_pend[sb.rs2])
             | (sb.rde  & eff_pend[sb.rd])
             | (sb.is_long & sb.rde & (sb.rd != '0) & full);
  end

  // Flush suppresses issue in the same cycle it is raised.
  assign run            = (state == ST_RUN) & ~sb.flush;
  assign sb.issue_valid = run & sb.dec_valid & ~hazard;
  assign sb.dec_ready   = run & sb.issue_ready & ~hazard;

  // Clear is applied before set so a same-cycle set of the same register
  // wins while outst sees +1 -1.
  always_comb begin
    fire      = sb.dec_valid & sb.dec_ready;
    set_en    = fire & sb.is_long & sb.rde & (sb.rd != '0);
    clr_en    = sb.wb_valid & pending[sb.wb_rd];
    set_mask  = set_en ? (NREG'(1) << sb.rd) : '0;
    clr_mask  = clr_en ? wb_mask : '0;
    pending_d = (pending & ~clr_mask) | set_mask;
    pending_d[0] = 1'b0;
    outst_d   = outst + OW'(set_en) - OW'(clr_en);
    stall_inc = (state == ST_RUN) & sb.dec_valid & ~sb.dec_ready;
  end

  // DRAIN leaves one cycle after outst is observed at zero.
  always_comb begin
    state_d = state;
    if (sb.flush) begin
      state_d = ST_DRAIN;
    end else if ((state == ST_DRAIN) && (outst == '0)) begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_RUN;
      pending   <= '0;
      outst     <= '0;
      stall_cnt <= '0;
      wb_err    <= 1'b0;
    end else begin
      state   <= state_d;
      pending <= pending_d;
      outst   <= outst_d;
      if (stall_inc && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      end
      if (sb.wb_valid && !clr_en) begin
        wb_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
module tb_issue_scoreboard;

  logic        clk;
  logic        reset;
  logic [31:0] pending;
  logic [2:0]  outst;
  logic [15:0] stall_cnt;
  logic        wb_err;

  issue_scoreboard_if #(.REG_WIDTH(5)) bus ();

  issue_scoreboard #(
    .REG_WIDTH(5),
    .MAX_OUTST(4),
    .CNT_WIDTH(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sb        (bus),
    .pending   (pending),
    .outst     (outst),
    .stall_cnt (stall_cnt),
    .wb_err    (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   passed = 0;
  int   total  = 0;

  // Reference model: set of pending registers, drain flag, counters.
  bit   m_pend [32];
  bit   m_drain;
  int   m_stall;
  bit   m_err;
  bit   exp_iv;
  bit   exp_dr;
  logic last_iv;
  logic last_dr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int pcount();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  function automatic logic [31:0] pvec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic bit busy(input logic [4:0] r);
    return (r != 0) && m_pend[r] && !(bus.wb_valid && bus.wb_rd == r);
  endfunction

  task automatic model_comb();
    bit hz;
    hz = (bus.rs1e && busy(bus.rs1)) || (bus.rs2e && busy(bus.rs2)) ||
         (bus.rde && busy(bus.rd)) ||
         (bus.is_long && bus.rde && bus.rd != 0 && pcount() == 4);
    exp_iv = !m_drain && !bus.flush && bus.dec_valid && !hz;
    exp_dr = !m_drain && !bus.flush && bus.issue_ready && !hz;
  endtask

  task automatic model_seq();
    int n;
    if (!reset) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 0;
      m_drain = 0;
      m_stall = 0;
      m_err   = 0;
    end else begin
      n = pcount();
      if (!m_drain && bus.dec_valid && !exp_dr && m_stall < 65535) m_stall++;
      if (bus.wb_valid) begin
        if (m_pend[bus.wb_rd]) m_pend[bus.wb_rd] = 0;
        else m_err = 1;
      end
      if (bus.dec_valid && exp_dr && bus.is_long && bus.rde && bus.rd != 0)
        m_pend[bus.rd] = 1;
      if (bus.flush) m_drain = 1;
      else if (m_drain && n == 0) m_drain = 0;
    end
  endtask

  task automatic step(input bit chk);
    #2;
    model_comb();
    last_iv = bus.issue_valid;
    last_dr = bus.dec_ready;
    if (chk) begin
      check("issue_valid", 64'(last_iv), 64'(exp_iv));
      check("dec_ready", 64'(last_dr), 64'(exp_dr));
    end
    @(posedge clk);
    model_seq();
    #1;
    if (chk) begin
      check("pending", 64'(pending), 64'(pvec()));
      check("outst", 64'(outst), 64'(pcount()));
      check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      check("wb_err", 64'(wb_err), 64'(m_err));
    end
  endtask

  task automatic idle();
    reset           = 1'b1;
    bus.dec_valid   = 1'b0;
    bus.rs1         = '0;
    bus.rs2         = '0;
    bus.rs1e        = 1'b0;
    bus.rs2e        = 1'b0;
    bus.rd          = '0;
    bus.rde         = 1'b0;
    bus.is_long     = 1'b0;
    bus.issue_ready = 1'b1;
    bus.wb_valid    = 1'b0;
    bus.wb_rd       = '0;
    bus.flush       = 1'b0;
  endtask

  task automatic load(input logic [4:0] r);
    idle();
    bus.dec_valid = 1'b1;
    bus.is_long   = 1'b1;
    bus.rde       = 1'b1;
    bus.rd        = r;
  endtask

  task automatic wb(input logic [4:0] r);
    idle();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = r;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    step(0);
    step(0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_outst", 64'(outst), 64'd0);
    check("rst_stall", 64'(stall_cnt), 64'd0);
    check("rst_wb_err", 64'(wb_err), 64'd0);

    // Load x5 then dependent add: stalls until the writeback cycle.
    load(5'd5);
    step(1);
    check("t1_pend5", 64'(pending[5]), 64'd1);
    idle();
    bus.dec_valid = 1'b1; bus.rs1 = 5'd5; bus.rs1e = 1'b1; bus.rd = 5'd10; bus.rde = 1'b1;
    step(1);
    check("t1_stall_a", 64'(last_iv), 64'd0);
    step(1);
    check("t1_stall_b", 64'(last_iv), 64'd0);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd5;
    step(1);
    check("t1_issue_on_wb", 64'(last_iv), 64'd1);
    check("t1_pend_clear", 64'(pending), 64'd0);

    // Four loads fill the table; fifth waits for a free slot.
    for (int i = 1; i <= 4; i++) begin
      load(5'(i));
      step(1);
    end
    check("t2_full", 64'(outst), 64'd4);
    load(5'd6);
    step(1);
    check("t2_5th_stall", 64'(last_iv), 64'd0);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd2;
    step(1);
    check("t2_wb_cycle", 64'(last_iv), 64'd0);
    bus.wb_valid = 1'b0;
    step(1);
    check("t2_5th_fire", 64'(last_iv), 64'd1);
    check("t2_outst4", 64'(outst), 64'd4);
    check("t2_mask", 64'(pending), 64'h5A);
    wb(5'd1); step(1);
    wb(5'd3); step(1);
    wb(5'd4); step(1);
    wb(5'd6); step(1);
    check("t2_empty", 64'(outst), 64'd0);

    // Register 0 is never tracked.
    load(5'd0);
    step(1);
    check("t3_pend0", 64'(pending), 64'd0);
    check("t3_outst0", 64'(outst), 64'd0);
    idle();
    bus.dec_valid = 1'b1; bus.rs1e = 1'b1; bus.rs2e = 1'b1; bus.rde = 1'b1;
    step(1);
    check("t3_x0_issue", 64'(last_iv), 64'd1);

    // Same-cycle set and clear of x7.
    load(5'd7);
    step(1);
    load(5'd7);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd7;
    step(1);
    check("t4_fire", 64'(last_iv), 64'd1);
    check("t4_pend7", 64'(pending), 64'h80);
    check("t4_outst", 64'(outst), 64'd1);

    // Flush with two loads outstanding.
    load(5'd8);
    step(1);
    check("t5_outst2", 64'(outst), 64'd2);
    idle(); bus.flush = 1'b1;
    step(1);
    idle(); bus.dec_valid = 1'b1; bus.rd = 5'd12; bus.rde = 1'b1;
    step(1);
    check("t5_drain_a", 64'(last_dr), 64'd0);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd7;
    step(1);
    check("t5_drain_b", 64'(last_dr), 64'd0);
    bus.wb_rd = 5'd8;
    step(1);
    check("t5_drained", 64'(outst), 64'd0);
    bus.wb_valid = 1'b0;
    step(1);
    check("t5_last_drain", 64'(last_dr), 64'd0);
    step(1);
    check("t5_resume", 64'(last_dr), 64'd1);

    // Writeback to a register that is not pending.
    wb(5'd9);
    step(1);
    check("t6_err", 64'(wb_err), 64'd1);
    check("t6_outst", 64'(outst), 64'd0);
    idle();
    step(1);
    check("t6_sticky", 64'(wb_err), 64'd1);

    // Random traffic over a small register window to provoke hazards.
    for (int n = 0; n < 2000; n++) begin
      reset           = ($urandom_range(0, 149) != 0);
      bus.flush       = ($urandom_range(0, 29) == 0);
      bus.dec_valid   = bus.flush ? 1'b0 : ($urandom_range(0, 2) != 0);
      bus.rs1         = 5'($urandom_range(0, 7));
      bus.rs2         = 5'($urandom_range(0, 7));
      bus.rd          = 5'($urandom_range(0, 7));
      bus.rs1e        = 1'($urandom_range(0, 1));
      bus.rs2e        = 1'($urandom_range(0, 1));
      bus.rde         = 1'($urandom_range(0, 1));
      bus.is_long     = ($urandom_range(0, 2) == 0);
      bus.issue_ready = ($urandom_range(0, 3) != 0);
      bus.wb_valid    = ($urandom_range(0, 2) == 0);
      bus.wb_rd       = 5'($urandom_range(0, 7));
      step(1);
    end

    // Long stall run saturates the counter.
    idle(); reset = 1'b0;
    step(1);
    idle(); bus.dec_valid = 1'b1; bus.issue_ready = 1'b0;
    for (int n = 0; n < 70000; n++) step(0);
    step(1);
    check("sat_stall", 64'(stall_cnt), 64'hFFFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
